// File: rtl/cpu4004_pkg.sv
// Shared constants for the 4004-style instruction-cycle controller:
// machine-cycle phase codes, accumulator command codes, opcode nibbles,
// and the small decode helpers used by instr_cycle_ctrl.
package cpu4004_pkg;

    localparam logic [2:0] A1 = 3'd0;
    localparam logic [2:0] A2 = 3'd1;
    localparam logic [2:0] A3 = 3'd2;
    localparam logic [2:0] M1 = 3'd3;
    localparam logic [2:0] M2 = 3'd4;
    localparam logic [2:0] X1 = 3'd5;
    localparam logic [2:0] X2 = 3'd6;
    localparam logic [2:0] X3 = 3'd7;

    localparam logic [1:0] ACC_HOLD  = 2'b00;
    localparam logic [1:0] ACC_LOAD  = 2'b01;
    localparam logic [1:0] ACC_DRIVE = 2'b10;
    localparam logic [1:0] ACC_CLEAR = 2'b11;

    localparam logic [3:0] OPR_JCN     = 4'h1;
    localparam logic [3:0] OPR_FIM_SRC = 4'h2;
    localparam logic [3:0] OPR_JUN     = 4'h4;
    localparam logic [3:0] OPR_JMS     = 4'h5;
    localparam logic [3:0] OPR_ISZ     = 4'h7;
    localparam logic [3:0] OPR_LD      = 4'hA;
    localparam logic [3:0] OPR_LDM     = 4'hD;
    localparam logic [3:0] OPR_GRP_E   = 4'hE;
    localparam logic [3:0] OPR_GRP_F   = 4'hF;

    typedef enum logic {
        SW_IDLE   = 1'b0,
        SW_SECOND = 1'b1
    } sw_state_e;

    // FIM and SRC share OPR 2; only the even-OPA form (FIM) carries a second word.
    function automatic logic is_two_word(input logic [3:0] opr, input logic [3:0] opa);
        return (opr == OPR_JCN) || (opr == OPR_JUN) || (opr == OPR_JMS) ||
               (opr == OPR_ISZ) || ((opr == OPR_FIM_SRC) && !opa[0]);
    endfunction

    function automatic logic [1:0] acc_decode(input logic [3:0] opr, input logic [3:0] opa);
        logic [1:0] cmd;
        cmd = ACC_HOLD;
        case (opr)
            OPR_LDM, OPR_LD: cmd = ACC_LOAD;
            OPR_GRP_F: begin
                if (opa == 4'h0)      cmd = ACC_CLEAR;
                else if (opa == 4'hD) cmd = ACC_DRIVE;
            end
            OPR_GRP_E: if (opa == 4'h1) cmd = ACC_DRIVE;
            default:   cmd = ACC_HOLD;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/instr_cycle_ctrl_phase_gen.sv
// Machine-cycle phase counter (A1..X3) with registered sync during X3.
// With SINGLE_STEP_EN defined, the counter parks at A1 until step is high;
// the remaining phases always run to completion.
module phase_gen
    import cpu4004_pkg::*;
#(
    parameter int PHASE_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef SINGLE_STEP_EN
    input  logic               step,
`endif
    output logic [PHASE_W-1:0] phase,
    output logic               sync
);

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               sync_q, sync_d;
    logic               advance;

    // Next phase: wrap naturally X3 -> A1; A1 may be held in single-step builds.
    always_comb begin
`ifdef SINGLE_STEP_EN
        advance = (phase_q != PHASE_W'(A1)) || step;
`else
        advance = 1'b1;
`endif
        phase_d = advance ? phase_q + PHASE_W'(1) : phase_q;
        sync_d  = (phase_d == PHASE_W'(X3));
    end

    // Phase and sync registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PHASE_W'(A1);
            sync_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            sync_q  <= sync_d;
        end
    end

    assign phase = phase_q;
    assign sync  = sync_q;

endmodule

// File: rtl/instr_cycle_ctrl.sv
// Instruction-cycle controller upstream of the accumulator: latches OPR/OPA
// in M1/M2, decodes accumulator commands for X2 and skips decode of the
// second word of two-word instructions.
// Optional feature: SINGLE_STEP_EN adds the step input (A1 hold).
//
// second-word FSM
//   state     | meaning
//   SW_IDLE   | current cycle fetches a normal opcode; decode enabled
//   SW_SECOND | current cycle fetches a two-word instruction's data word
module instr_cycle_ctrl
    import cpu4004_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int PHASE_W    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_bus_in,
    output logic [DATA_WIDTH-1:0] data_bus_out,
    output logic                  data_bus_oe,
    output logic [1:0]            accumulator_enable,
    output logic [PHASE_W-1:0]    phase,
    output logic                  sync,
    output logic [DATA_WIDTH-1:0] opr,
    output logic [DATA_WIDTH-1:0] opa,
`ifdef SINGLE_STEP_EN
    input  logic                  step,
`endif
    output logic                  second_word
);

    logic [DATA_WIDTH-1:0] opr_q, opa_q, dout_q, dout_d;
    logic [1:0]            acc_q, acc_d;
    logic                  oe_q, oe_d;
    sw_state_e             sw_state_q, sw_state_d;

    phase_gen #(.PHASE_W(PHASE_W)) u_phase_gen (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef SINGLE_STEP_EN
        .step  (step),
`endif
        .phase (phase),
        .sync  (sync)
    );

    // Decode lands on the edge leaving X1 so the command is visible only in X2.
    always_comb begin
        acc_d  = ACC_HOLD;
        oe_d   = 1'b0;
        dout_d = '0;
        if ((phase == PHASE_W'(X1)) && (sw_state_q == SW_IDLE)) begin
            acc_d = acc_decode(opr_q, opa_q);
            if (opr_q == OPR_LDM) begin
                oe_d   = 1'b1;
                dout_d = opa_q;
            end
        end
    end

    // Fetch latches and registered accumulator/bus outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opr_q  <= '0;
            opa_q  <= '0;
            acc_q  <= ACC_HOLD;
            oe_q   <= 1'b0;
            dout_q <= '0;
        end else begin
            if (phase == PHASE_W'(M1)) opr_q <= data_bus_in;
            if (phase == PHASE_W'(M2)) opa_q <= data_bus_in;
            acc_q  <= acc_d;
            oe_q   <= oe_d;
            dout_q <= dout_d;
        end
    end

    // Second-word FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sw_state_q <= SW_IDLE;
        else        sw_state_q <= sw_state_d;
    end

    // Second-word FSM transitions, taken only on the edge leaving X3.
    always_comb begin
        sw_state_d = sw_state_q;
        if (phase == PHASE_W'(X3)) begin
            case (sw_state_q)
                SW_IDLE:   if (is_two_word(opr_q, opa_q)) sw_state_d = SW_SECOND;
                SW_SECOND: sw_state_d = SW_IDLE;
                default:   sw_state_d = SW_IDLE;
            endcase
        end
    end

    // Second-word FSM output.
    always_comb begin
        second_word = (sw_state_q == SW_SECOND);
    end

    assign accumulator_enable = acc_q;
    assign data_bus_oe        = oe_q;
    assign data_bus_out       = dout_q;
    assign opr                = opr_q;
    assign opa                = opa_q;

endmodule

// File: tb/tb_instr_cycle_ctrl.sv
// Self-checking bench for instr_cycle_ctrl: directed opcode cycles followed by
// random opcodes, compared against a cycle-level model of the instruction stream.
module tb_instr_cycle_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] data_bus_in;
    logic [3:0] data_bus_out;
    logic       data_bus_oe;
    logic [1:0] accumulator_enable;
    logic [2:0] phase;
    logic       sync;
    logic [3:0] opr;
    logic [3:0] opa;
    logic       second_word;
`ifdef SINGLE_STEP_EN
    logic       step;
`endif

    int checks   = 0;
    int failures = 0;
    bit m_sw     = 1'b0;

    instr_cycle_ctrl dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .data_bus_in        (data_bus_in),
        .data_bus_out       (data_bus_out),
        .data_bus_oe        (data_bus_oe),
        .accumulator_enable (accumulator_enable),
        .phase              (phase),
        .sync               (sync),
        .opr                (opr),
        .opa                (opa),
`ifdef SINGLE_STEP_EN
        .step               (step),
`endif
        .second_word        (second_word)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] m_acc(input logic [3:0] o, input logic [3:0] a);
        if (o == 4'hD || o == 4'hA) return 2'b01;
        if (o == 4'hF && a == 4'h0) return 2'b11;
        if (o == 4'hF && a == 4'hD) return 2'b10;
        if (o == 4'hE && a == 4'h1) return 2'b10;
        return 2'b00;
    endfunction

    function automatic bit m_two(input logic [3:0] o, input logic [3:0] a);
        return (o == 4'h1 || o == 4'h4 || o == 4'h5 || o == 4'h7 || (o == 4'h2 && a[0] == 1'b0));
    endfunction

    // One full machine cycle starting at the negedge inside A1. abort_at < 8
    // asserts reset shortly after the checks of that phase.
    task automatic run_cycle(input logic [3:0] o, input logic [3:0] a, input int abort_at);
        logic [1:0] e_acc;
        bit         e_oe;
        for (int k = 0; k < 8; k++) begin
            e_acc = (k == 6 && !m_sw) ? m_acc(o, a) : 2'b00;
            e_oe  = (k == 6 && !m_sw && o == 4'hD);
            chk($sformatf("phase k%0d", k), 32'(phase), 32'(k));
            chk($sformatf("sync k%0d", k), 32'(sync), 32'(k == 7));
            chk($sformatf("acc %h%h k%0d", o, a, k), 32'(accumulator_enable), 32'(e_acc));
            chk($sformatf("oe %h%h k%0d", o, a, k), 32'(data_bus_oe), 32'(e_oe));
            chk($sformatf("sw %h%h k%0d", o, a, k), 32'(second_word), 32'(m_sw));
            if (e_oe) chk("dout ldm", 32'(data_bus_out), 32'(a));
            if (k == 4) chk("opr latch", 32'(opr), 32'(o));
            if (k == 5) chk("opa latch", 32'(opa), 32'(a));
            data_bus_in = (k == 3) ? o : (k == 4) ? a : 4'($urandom_range(0, 15));
`ifdef SINGLE_STEP_EN
            step = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
`endif
            if (k == abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rst acc", 32'(accumulator_enable), 32'(0));
                chk("rst oe", 32'(data_bus_oe), 32'(0));
                chk("rst phase", 32'(phase), 32'(0));
                chk("rst sw", 32'(second_word), 32'(0));
                @(negedge clk);
                rst_n = 1'b1;
                m_sw  = 1'b0;
                return;
            end
            @(posedge clk);
            @(negedge clk);
        end
        m_sw = (!m_sw && m_two(o, a));
    endtask

    initial begin
        rst_n       = 1'b0;
        data_bus_in = 4'h0;
`ifdef SINGLE_STEP_EN
        step        = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("reset phase", 32'(phase), 32'(0));
        chk("reset sync", 32'(sync), 32'(0));
        chk("reset opr", 32'(opr), 32'(0));
        chk("reset opa", 32'(opa), 32'(0));
        chk("reset acc", 32'(accumulator_enable), 32'(0));
        chk("reset oe", 32'(data_bus_oe), 32'(0));
        chk("reset dout", 32'(data_bus_out), 32'(0));
        chk("reset sw", 32'(second_word), 32'(0));
        rst_n = 1'b1;

        // LDM interrupted by reset in X2, then clean directed cycles.
        run_cycle(4'hD, 4'h9, 6);
        run_cycle(4'hD, 4'h9, 8);
        run_cycle(4'hF, 4'h0, 8);
        run_cycle(4'hE, 4'h1, 8);
        run_cycle(4'hF, 4'hD, 8);
        run_cycle(4'hA, 4'h5, 8);
        run_cycle(4'h4, 4'h0, 8);   // JUN
        run_cycle(4'hD, 4'h5, 8);   //   second word, not an LDM
        run_cycle(4'hD, 4'h3, 8);
        run_cycle(4'h2, 4'h2, 8);   // FIM
        run_cycle(4'hF, 4'h0, 8);   //   second word, not a CLB
        run_cycle(4'h2, 4'h3, 8);   // SRC: single word
        run_cycle(4'hD, 4'h1, 8);
        run_cycle(4'h5, 4'h0, 8);   // JMS
        run_cycle(4'h4, 4'h4, 8);   //   second word looks like JUN, must not re-arm
        run_cycle(4'hD, 4'h2, 8);

`ifdef SINGLE_STEP_EN
        step = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold phase", 32'(phase), 32'(0));
            chk("hold acc", 32'(accumulator_enable), 32'(0));
            chk("hold oe", 32'(data_bus_oe), 32'(0));
        end
        run_cycle(4'hD, 4'h7, 8);
        step = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rehold phase", 32'(phase), 32'(0));
        end
`endif

        for (int n = 0; n < 80; n++) begin
            logic [3:0] ro, ra;
            ro = 4'($urandom_range(0, 15));
            ra = 4'($urandom_range(0, 15));
            run_cycle(ro, ra, 8);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_cycle_ctrl.md
Name: instr_cycle_ctrl

Overview:
- 4004-style instruction-cycle controller sitting directly upstream of the accumulator.
- Generates the 8-phase machine cycle (A1 A2 A3 M1 M2 X1 X2 X3) and latches the OPR/OPA nibbles fetched from ROM during M1/M2.
- Decodes accumulator-affecting opcodes and drives the accumulator's 2-bit accumulator_enable code plus an immediate nibble onto the shared 4-bit data_bus during X2.
- Tracks two-word instructions so that their second word is never decoded.

Parameters:
- DATA_WIDTH, 4, bus and nibble width; only 4 is supported.
- PHASE_W, 3, width of the phase counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- data_bus_in  in  4  nibble currently on data_bus, sampled in M1/M2
- data_bus_out  out  4  nibble this block drives onto data_bus
- data_bus_oe  out  1  tri-state enable for data_bus_out
- accumulator_enable  out  2  command to accumulator: 00 hold, 01 load A from data_bus, 10 A drives data_bus, 11 clear A
- phase  out  3  current phase: A1=0 A2=1 A3=2 M1=3 M2=4 X1=5 X2=6 X3=7
- sync  out  1  high during X3 (marks next cycle start)
- opr  out  4  latched opcode high nibble
- opa  out  4  latched opcode low nibble
- second_word  out  1  high for the whole cycle that fetches a two-word instruction's second word
- step  in  1  single-step request (present only with SINGLE_STEP_EN)

Behaviour:
- Clock and reset:
  - Single clock.
  - rst_n is asynchronous, active-low.
- Reset values:
  - phase=A1, sync=0, opr=0, opa=0.
  - accumulator_enable=00, data_bus_out=0, data_bus_oe=0, second_word=0.
  - Reset mid-cycle aborts the instruction immediately; no partial accumulator command survives.
- Phase counter:
  - Increments by 1 each clk and wraps X3 to A1.
  - sync is registered so that it is high exactly while phase==X3.
- Fetch:
  - On the edge leaving M1, opr <= data_bus_in.
  - On the edge leaving M2, opa <= data_bus_in.
  - Both nibbles are latched in every cycle, including second-word cycles. In a second-word cycle they hold the data/address word.
- Decode:
  - Decoding happens on the edge leaving X1.
  - All outputs are registered, so the command is valid for exactly the one cycle with phase==X2. Outside X2, accumulator_enable=00 and data_bus_oe=0.
  - Decode table, applied only when second_word==0:
    - opr=D (LDM): accumulator_enable=01, data_bus_oe=1, data_bus_out=opa.
    - opr=F, opa=0 (CLB): 11.
    - opr=F, opa=D (DCL) or opr=E, opa=1 (WMP): 10.
    - opr=A (LD): 01. The register file drives the bus, so oe=0.
    - All other opcodes: 00.
- Two-word detection:
  - Two-word opcodes are opr in {1,4,5,7}, or opr=2 with opa[0]=0 (FIM).
  - On such an opcode, at the edge leaving X3, second_word <= 1.
  - During the following cycle, decode is suppressed and accumulator_enable stays 00.
  - At the end of that cycle's X3, second_word <= 0.
  - A second word never re-arms second_word, even if its bits match a two-word opcode.
- Width: all nibble handling is unsigned 4-bit; there is no arithmetic beyond the phase wrap.

Optional Feature:
- Macro: SINGLE_STEP_EN.
- Defined:
  - The step port exists.
  - The counter holds at A1 while step==0; A1 advances only on a cycle where step==1. The other phases run freely.
  - While held, all outputs stay at their A1 values (accumulator_enable=00, oe=0).
  - A step asserted in any phase other than A1 is ignored.
- Undefined:
  - No step port.
  - The counter free-runs; behaviour is identical to the defined case with step tied to 1.

Decomposition:
- Shared package cpu4004_pkg holds:
  - phase localparams A1..X3
  - accumulator_enable codes ACC_HOLD/ACC_LOAD/ACC_DRIVE/ACC_CLEAR
  - opcode nibble constants OPR_LDM, OPR_LD, OPR_FIM_SRC, OPR_JCN, OPR_JUN, OPR_JMS, OPR_ISZ, OPR_GRP_E, OPR_GRP_F
- Sub-module phase_gen: the counter, the sync output and the SINGLE_STEP_EN hold logic.
- The decode table and the second_word FSM stay in the top module.

Test Plan:
- Reset:
  - Stimulus: assert rst_n=0 mid-X2 while an LDM command is active.
  - Required: accumulator_enable=00, oe=0 and phase=0 immediately, asynchronously.
  - Required after release: first sync after 8 clocks.
- LDM:
  - Stimulus: fetch 0xD then 0x9 in M1/M2.
  - Required in X2: accumulator_enable=01, data_bus_oe=1, data_bus_out=9. All other phases: 00, oe=0.
- CLB and WMP:
  - Stimulus: fetch F0.
  - Required in X2: accumulator_enable=11.
  - Stimulus: fetch E1.
  - Required in X2: accumulator_enable=10, oe=0.
- Two-word:
  - Stimulus: fetch 0x40 (JUN) then second word 0xD5.
  - Required: second_word=1 for the whole second cycle, accumulator_enable stays 00 (no LDM), second_word=0 after that cycle's X3.
- FIM vs SRC:
  - Stimulus: fetch 0x22.
  - Required: second_word=1 for the next cycle.
  - Stimulus: fetch 0x23.
  - Required: second_word stays 0.
- SINGLE_STEP_EN:
  - Stimulus: hold step=0 for 20 clocks.
  - Required: phase stays 0.
  - Stimulus: pulse step for one clock.
  - Required: exactly one full 8-phase cycle, then hold at A1 again.
